// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the binary-GCD unit.
// Holds the FSM state encoding and the cycle-counter width function.
// No logic; imported by gcd_step and gcd_unit.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter width able to hold 4*w+1 reduction cycles (the worst case).
  function automatic int cnt_width(input int w);
    return $clog2(4 * w + 2);
  endfunction

  // Width of the common power-of-two exponent K.
  function automatic int k_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One binary-GCD reduction step (halve common factor / halve even / subtract).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the outputs.
// Ports: x, y, k   current reduction state
//        x_nxt, y_nxt, k_nxt   state after one step (only meaningful if x!=0 and y!=0)
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = k_width(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] x_nxt,
  output logic [WIDTH-1:0] y_nxt,
  output logic [KW-1:0]    k_nxt
);

  localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    k_nxt = k;
    if (!x[0] && !y[0]) begin
      // Both even: strip the shared factor of two and remember it in K.
      x_nxt = x >> 1;
      y_nxt = y >> 1;
      k_nxt = k + K_ONE;
    end else if (!x[0]) begin
      x_nxt = x >> 1;
    end else if (!y[0]) begin
      y_nxt = y >> 1;
    end else if (x >= y) begin
      // Both odd: the difference is even, so the next step shifts it.
      x_nxt = x - y;
    end else begin
      y_nxt = y - x;
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// Iterative binary GCD of two unsigned operands, one operation in flight.
// Latency: 1 accept cycle + up to 4*WIDTH+1 REDUCE cycles, then result held.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
// Ports: clk, rst (async active-low)
//        in_valid/in_ready/a/b      operand handshake
//        out_valid/out_ready/ret/cycles   result handshake, cycles = REDUCE count
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = gcd_pkg::cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ret,
  output logic [CW-1:0]    cycles
);

  localparam int KW = k_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] x_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [KW-1:0]    k_nxt;

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .x     (x),
    .y     (y),
    .k     (k),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .k_nxt (k_nxt)
  );

  // The counter register doubles as the reported cycle count; it is frozen
  // outside REDUCE, so it stays stable for the whole DONE hold.
  assign cycles = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      k         <= '0;
      cnt       <= '0;
      ret       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x        <= a;
            y        <= b;
            k        <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= REDUCE;
          end
        end
        REDUCE: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
          if (x == '0 || y == '0) begin
            // One side is zero: the other holds the odd part of the GCD.
            ret       <= (x | y) << k;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            x <= x_nxt;
            y <= y_nxt;
            k <= k_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_unit.sv
module tb_gcd_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] a8, b8, ret8;
  logic [5:0] cyc8;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16, ret16;
  logic [6:0]  cyc16;

  gcd_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .ret(ret8), .cycles(cyc8)
  );

  gcd_unit #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .ret(ret16), .cycles(cyc16)
  );

  typedef struct {
    logic [15:0] ret;
    int          cyc_exact;  // -1 means only the bound is checked
    int          cyc_max;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   tests = 0;
  int   fails = 0;
  int   xfer8 = 0;
  int   xfer16 = 0;
  bit   rand_rdy = 1'b0;

  // Euclid by remainder: independent of the binary algorithm in the DUT.
  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_le(input string name, input logic [63:0] act, input logic [63:0] lim);
    tests++;
    if ($isunknown(act) || act > lim) begin
      fails++;
      $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
    end
  endtask

  task automatic mon8();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && ov8 === 1'b1 && or8 === 1'b1) begin
        xfer8++;
        if (q8.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out8: got ret=%0d cycles=%0d, required no output", ret8, cyc8);
        end else begin
          e = q8.pop_front();
          chk("ret8", ret8, e.ret);
          if (e.cyc_exact >= 0) chk("cycles8", cyc8, e.cyc_exact);
          else chk_le("cycles8_bound", cyc8, e.cyc_max);
        end
      end
    end
  endtask

  task automatic mon16();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && ov16 === 1'b1 && or16 === 1'b1) begin
        xfer16++;
        if (q16.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out16: got ret=%0d cycles=%0d, required no output", ret16, cyc16);
        end else begin
          e = q16.pop_front();
          chk("ret16", ret16, e.ret);
          if (e.cyc_exact >= 0) chk("cycles16", cyc16, e.cyc_exact);
          else chk_le("cycles16_bound", cyc16, e.cyc_max);
        end
      end
    end
  endtask

  task automatic rdy16_driver();
    forever begin
      @(posedge clk);
      #1;
      or16 = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                       input int cx, input int cm, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (ir8 !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (ir8 !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept8_timeout: in_ready=%b, required 1", ir8);
      return;
    end
    a8 = a; b8 = b; iv8 = 1'b1;
    if (push) begin
      e.ret = {8'd0, r}; e.cyc_exact = cx; e.cyc_max = cm;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    int   n;
    exp_t e;
    n = 0;
    while (ir16 !== 1'b1 && n < 600) begin
      @(posedge clk); #1; n++;
    end
    if (ir16 !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept16_timeout: in_ready=%b, required 1", ir16);
      return;
    end
    a16 = a; b16 = b; iv16 = 1'b1;
    e.ret = 16'(ref_gcd(a, b)); e.cyc_exact = -1; e.cyc_max = 65;
    q16.push_back(e);
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic drain(input bit wide);
    int n;
    n = 0;
    while ((wide ? q16.size() : q8.size()) != 0 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if ((wide ? q16.size() : q8.size()) != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", wide ? q16.size() : q8.size());
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    int x0;
    int n;
    logic [15:0] ra, rb;
    logic [7:0]  sa, sb;

    rst = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready8", ir8, 1);
    chk("rst_out_valid8", ov8, 0);
    chk("rst_ret8", ret8, 0);
    chk("rst_cycles8", cyc8, 0);
    chk("rst_in_ready16", ir16, 1);
    chk("rst_out_valid16", ov16, 0);
    rst = 1'b1;

    fork
      mon8();
      mon16();
      rdy16_driver();
    join_none

    // Main example, accepted on the very first edge with reset high.
    x0 = xfer8;
    send8(8'd48, 8'd18, 8'd6, 8, 0, 1'b1);
    drain(1'b0);
    chk("one_pulse_48_18", xfer8 - x0, 1);

    // Zero operands and equal / unit operands.
    send8(8'd0, 8'd0, 8'd0, 1, 0, 1'b1);
    send8(8'd0, 8'd7, 8'd7, 1, 0, 1'b1);
    send8(8'd9, 8'd0, 8'd9, 1, 0, 1'b1);
    send8(8'd255, 8'd255, 8'd255, 2, 0, 1'b1);
    send8(8'd255, 8'd1, 8'd1, -1, 33, 1'b1);
    drain(1'b0);

    // A short random run at WIDTH=8.
    for (int i = 0; i < 40; i++) begin
      sa = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      send8(sa, sb, 8'(ref_gcd(sa, sb)), -1, 33, 1'b1);
    end
    drain(1'b0);

    // Backpressure: result held 5 cycles, a competing in_valid must be ignored.
    x0 = xfer8;
    or8 = 1'b0;
    send8(8'd48, 8'd18, 8'd6, 8, 0, 1'b1);
    n = 0;
    while (ov8 !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("bp_out_valid_seen", ov8, 1);
    @(posedge clk); #1;
    iv8 = 1'b1; a8 = 8'd100; b8 = 8'd75;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ret_stable", ret8, 6);
      chk("bp_cycles_stable", cyc8, 8);
      chk("bp_in_ready_low", ir8, 0);
      chk("bp_out_valid_high", ov8, 1);
    end
    @(posedge clk); #1;
    or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("bp_in_ready_after", ir8, 1);
    chk("bp_out_valid_after", ov8, 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_one_transfer", xfer8 - x0, 1);

    // Reset mid-REDUCE aborts the operation with no result.
    x0 = xfer8;
    send8(8'd48, 8'd18, 8'd0, 0, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("abort_out_valid", ov8, 0);
    chk("abort_in_ready", ir8, 1);
    chk("abort_cycles_clr", cyc8, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("abort_no_result", xfer8 - x0, 0);
    send8(8'd12, 8'd8, 8'd4, 7, 0, 1'b1);
    drain(1'b0);

    // WIDTH=16 random pairs against Euclid, with random output backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 4))
        0: begin ra = 16'($urandom); rb = 16'($urandom); end
        1: begin ra = 16'($urandom); rb = 16'($urandom_range(0, 15)); end
        2: begin
          n  = $urandom_range(0, 8);
          ra = 16'($urandom_range(1, 255) << n);
          rb = 16'($urandom_range(1, 255) << n);
        end
        3: begin ra = 16'($urandom_range(0, 1) ? $urandom : 0); rb = (ra == 0) ? 16'($urandom) : 16'd0; end
        default: begin ra = 16'($urandom); rb = ra; end
      endcase
      send16(ra, rb);
    end
    drain(1'b1);
    rand_rdy = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
